// File: rtl/osd_text_overlay.sv
// OSD text renderer: streams raster frames and overlays a short string whose glyphs come from an
// external font ROM sheet (16x16 glyph grid). Three stages: raster counters -> font address -> pixel.
module osd_text_overlay #(
    parameter int STRING_LENGTH = 4,
    parameter int CHAR_ENCODING = 8,
    parameter int LAST_CHAR     = 255,
    parameter int BPP           = 12,
    parameter int MSB_BPP       = 8,
    parameter int PAGES         = 1,
    parameter int PNG_W         = 256,
    parameter int PNG_H         = 256,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int FPS           = 25,
    parameter int CLK_PERIOD    = 100,
    parameter int COLORED       = 1,
    parameter int DATA_WIDTH    = (COLORED != 0) ? 3 * MSB_BPP : MSB_BPP,
    localparam int XW           = $clog2(FRAME_W - 2) + 1,
    localparam int YW           = $clog2(FRAME_H - 2) + 1,
    localparam int AW           = $clog2(PAGES * PNG_W * PNG_H)
) (
    input  logic                                  i_sys_clk,
    input  logic                                  i_rstb,
    input  logic                                  i_read,
    input  logic [CHAR_ENCODING*STRING_LENGTH-1:0] i_str,
    input  logic [DATA_WIDTH*STRING_LENGTH-1:0]    i_str_color,
    input  logic [XW-1:0]                          i_start_x,
    input  logic [YW-1:0]                          i_start_y,
    output logic [AW-1:0]                          o_font_addr,
    input  logic [BPP-1:0]                         i_font_data,
    output logic                                  o_frame_start,
    output logic                                  o_pix_valid,
    output logic [XW-1:0]                          o_pix_x,
    output logic [YW-1:0]                          o_pix_y,
    output logic                                  o_pix_ovl,
    output logic [DATA_WIDTH-1:0]                  o_pix_data
);

    localparam int GW        = PNG_W / 16;
    localparam int GH        = PNG_H / 16;
    localparam int NPIX      = FRAME_W * FRAME_H;
    localparam int FRAME_CYC = 1000000000 / (FPS * CLK_PERIOD);
    localparam int CW        = $clog2(((FRAME_CYC > NPIX) ? FRAME_CYC : NPIX) + 1);
    localparam int SW        = CHAR_ENCODING * STRING_LENGTH;
    localparam int CDW       = DATA_WIDTH * STRING_LENGTH;

    localparam logic [XW:0]         BOX_W     = (XW+1)'(GW * STRING_LENGTH);
    localparam logic [YW:0]         BOX_H     = (YW+1)'(GH);
    localparam logic [XW:0]         GW_W      = (XW+1)'(GW);
    localparam logic [XW-1:0]       X_LAST    = XW'(FRAME_W - 1);
    localparam logic [YW-1:0]       Y_LAST    = YW'(FRAME_H - 1);
    localparam logic [CW-1:0]       CYC_LAST  = CW'(FRAME_CYC - 1);
    localparam logic [MSB_BPP-1:0]  ALPHA_MIN = {1'b1, {(MSB_BPP-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [CW-1:0]    r_cyc;
    logic [SW-1:0]    r_str;
    logic [CDW-1:0]   r_col;
    logic [XW-1:0]    r_sx;
    logic [YW-1:0]    r_sy;

    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_hit;
    logic [XW-1:0]    r_s1_x;
    logic [YW-1:0]    r_s1_y;
    logic [DATA_WIDTH-1:0] r_s1_color;

    logic [XW:0]      w_dx;
    logic [YW:0]      w_dy;
    logic [XW:0]      w_k;
    logic             w_in_x;
    logic             w_in_y;
    logic             w_hit;
    logic             w_ovl;
    logic [CHAR_ENCODING-1:0] w_code;
    logic [DATA_WIDTH-1:0]    w_color;
    logic [AW-1:0]    w_addr;
    logic             w_unused_font_lsb;

    // Frame sequencer: raster counters, frame-period counter and per-frame parameter shadows.
    always_ff @(posedge i_sys_clk) begin
        if (i_rstb) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_cyc   <= '0;
            r_str   <= '0;
            r_col   <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_read) begin
                        r_state <= S_ACTIVE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_cyc   <= '0;
                        r_str   <= i_str;
                        r_col   <= i_str_color;
                        r_sx    <= i_start_x;
                        r_sy    <= i_start_y;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (r_x == X_LAST) begin
                        r_x <= '0;
                        if (r_y == Y_LAST) begin
                            r_y <= '0;
                            // Frame period no longer than the pixel count: restart without blanking.
                            if (r_cyc >= CYC_LAST) begin
                                r_cyc <= '0;
                                r_str <= i_str;
                                r_col <= i_str_color;
                                r_sx  <= i_start_x;
                                r_sy  <= i_start_y;
                            end else begin
                                r_state <= S_BLANK;
                                r_cyc   <= r_cyc + CW'(1'b1);
                            end
                        end else begin
                            r_y   <= r_y + YW'(1'b1);
                            r_cyc <= r_cyc + CW'(1'b1);
                        end
                    end else begin
                        r_x   <= r_x + XW'(1'b1);
                        r_cyc <= r_cyc + CW'(1'b1);
                    end
                end
                S_BLANK: begin
                    if (r_cyc >= CYC_LAST) begin
                        r_state <= S_ACTIVE;
                        r_cyc   <= '0;
                        r_str   <= i_str;
                        r_col   <= i_str_color;
                        r_sx    <= i_start_x;
                        r_sy    <= i_start_y;
                    end else begin
                        r_cyc <= r_cyc + CW'(1'b1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Text-box hit test and glyph address; one extra bit on each coordinate keeps the right edge from wrapping.
    always_comb begin
        w_dx    = {1'b0, r_x} - {1'b0, r_sx};
        w_dy    = {1'b0, r_y} - {1'b0, r_sy};
        w_in_x  = (r_x >= r_sx) && ({1'b0, r_x} < ({1'b0, r_sx} + BOX_W));
        w_in_y  = (r_y >= r_sy) && ({1'b0, r_y} < ({1'b0, r_sy} + BOX_H));
        w_k     = w_dx / GW_W;
        w_code  = '0;
        w_color = '0;
        for (int i = 0; i < STRING_LENGTH; i++) begin
            w_code  = (w_k == (XW+1)'(i)) ? r_str[(STRING_LENGTH-1-i)*CHAR_ENCODING +: CHAR_ENCODING] : w_code;
            w_color = (w_k == (XW+1)'(i)) ? r_col[(STRING_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH] : w_color;
        end
        w_hit  = (r_state == S_ACTIVE) && w_in_x && w_in_y && (32'(w_code) <= 32'(LAST_CHAR));
        w_addr = AW'((32'(w_code) / 32'd256) * 32'(PNG_W * PNG_H)
                   + ((32'(w_code) % 32'd256) / 32'd16 * 32'(GH) + 32'(w_dy)) * 32'(PNG_W)
                   + (32'(w_code) % 32'd16) * 32'(GW)
                   + 32'(w_dx % GW_W));
    end

    // Address stage: font ROM address plus the pixel sideband that travels alongside it.
    always_ff @(posedge i_sys_clk) begin
        if (i_rstb) begin
            o_font_addr <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_color  <= '0;
        end else begin
            o_font_addr <= w_hit ? w_addr : '0;
            r_s1_valid  <= (r_state == S_ACTIVE);
            r_s1_first  <= (r_state == S_ACTIVE) && (r_x == '0) && (r_y == '0);
            r_s1_hit    <= w_hit;
            r_s1_x      <= r_x;
            r_s1_y      <= r_y;
            r_s1_color  <= w_hit ? w_color : '0;
        end
    end

    assign w_ovl             = r_s1_hit && (i_font_data[BPP-1 -: MSB_BPP] >= ALPHA_MIN);
    assign w_unused_font_lsb = ^i_font_data;

    // Pixel stage: alpha threshold on the returned glyph word.
    always_ff @(posedge i_sys_clk) begin
        if (i_rstb) begin
            o_frame_start <= 1'b0;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_ovl     <= 1'b0;
            o_pix_data    <= '0;
        end else begin
            o_frame_start <= r_s1_first;
            o_pix_valid   <= r_s1_valid;
            o_pix_x       <= r_s1_x;
            o_pix_y       <= r_s1_y;
            o_pix_ovl     <= w_ovl;
            o_pix_data    <= w_ovl ? r_s1_color : '0;
        end
    end

endmodule

// File: tb/tb_osd_text_overlay.sv
// Bench for osd_text_overlay on a reduced 80x30 frame (2500-cycle period) with a hashed font ROM whose
// space glyph is blank; every pixel is compared with a coordinate-level model of the text box.
module tb_osd_text_overlay;

    localparam int FW = 80, FH = 30, NPIX = FW * FH, FCYC = 2500;

    logic        clk = 1'b0;
    logic        rstb, read;
    logic [31:0] str;
    logic [95:0] col;
    logic [7:0]  sx;
    logic [5:0]  sy;
    logic [15:0] font_addr;
    logic [11:0] font_data;
    logic        frame_start, pix_valid, pix_ovl;
    logic [7:0]  pix_x;
    logic [5:0]  pix_y;
    logic [23:0] pix_data;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_str, p_str;
    logic [95:0] m_col, p_col;
    int          m_sx, m_sy;
    logic [7:0]  p_sx;
    logic [5:0]  p_sy;

    int          cap_addr [NPIX];
    bit          cap_ovl  [NPIX];
    logic [23:0] cap_data [NPIX];

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_word(input logic [15:0] a);
        int unsigned h;
        if (a[15:8] >= 8'd32 && a[15:8] <= 8'd47 && a[7:0] < 8'd16) return 12'h000;
        h = {16'h0000, a} * 32'h9E3779B1;
        return h[27:16];
    endfunction

    assign font_data = rom_word(font_addr);

    osd_text_overlay #(.FRAME_W(FW), .FRAME_H(FH), .FPS(1000), .CLK_PERIOD(400)) dut (
        .i_sys_clk(clk), .i_rstb(rstb), .i_read(read), .i_str(str), .i_str_color(col),
        .i_start_x(sx), .i_start_y(sy), .o_font_addr(font_addr), .i_font_data(font_data),
        .o_frame_start(frame_start), .o_pix_valid(pix_valid), .o_pix_x(pix_x), .o_pix_y(pix_y),
        .o_pix_ovl(pix_ovl), .o_pix_data(pix_data)
    );

    function automatic void model(input int x, input int y, output int addr, output bit ovl,
                                  output logic [23:0] data);
        int k, c, gx, gy;
        logic [31:0] ts;
        logic [95:0] tc;
        logic [11:0] w;
        addr = 0; ovl = 1'b0; data = 24'h0;
        if (x >= m_sx && x < m_sx + 64 && y >= m_sy && y < m_sy + 16) begin
            k  = (x - m_sx) / 16;
            gx = (x - m_sx) % 16;
            gy = y - m_sy;
            ts = m_str >> (8 * (3 - k));
            c  = int'(ts[7:0]);
            addr = (c / 256) * 65536 + ((c % 256) / 16 * 16 + gy) * 256 + (c % 16) * 16 + gx;
            w   = rom_word(16'(addr));
            ovl = w[11];
            tc  = m_col >> (24 * (3 - k));
            if (ovl) data = tc[23:0];
        end
    endfunction

    task automatic wait_fs(input string tag, input int bound, output int n);
        n = 0;
        while (frame_start !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_start timeout: got %b after %0d clk, required 1", tag, frame_start, n);
        end
    endtask

    // Checks one whole frame from the frame_start cycle; p_* inputs are applied at pixel change_at.
    task automatic check_frame(input string tag, input int change_at);
        int a, na, ex, ey;
        bit o, no;
        logic [23:0] d, nd;
        m_str = str; m_col = col; m_sx = int'(sx); m_sy = int'(sy);
        cap_addr[0] = 0;
        for (int p = 0; p < NPIX; p++) begin
            ex = p % FW; ey = p / FW;
            model(ex, ey, a, o, d);
            n_checks += 6;
            if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL %s pix_valid p=%0d got %b exp 1", tag, p, pix_valid); end
            if (frame_start !== (p == 0)) begin n_fail++; $display("FAIL %s frame_start p=%0d got %b exp %0d", tag, p, frame_start, p == 0); end
            if (pix_x !== 8'(ex)) begin n_fail++; $display("FAIL %s pix_x p=%0d got %0d exp %0d", tag, p, pix_x, ex); end
            if (pix_y !== 6'(ey)) begin n_fail++; $display("FAIL %s pix_y p=%0d got %0d exp %0d", tag, p, pix_y, ey); end
            if (pix_ovl !== o) begin n_fail++; $display("FAIL %s pix_ovl (%0d,%0d) got %b exp %b", tag, ex, ey, pix_ovl, o); end
            if (pix_data !== d) begin n_fail++; $display("FAIL %s pix_data (%0d,%0d) got %h exp %h", tag, ex, ey, pix_data, d); end
            cap_ovl[p] = pix_ovl;
            cap_data[p] = pix_data;
            if (p + 1 < NPIX) begin
                model((p + 1) % FW, (p + 1) / FW, na, no, nd);
                cap_addr[p + 1] = int'(font_addr);
                n_checks++;
                if (font_addr !== 16'(na)) begin
                    n_fail++;
                    $display("FAIL %s font_addr (%0d,%0d) got %0d exp %0d", tag, (p + 1) % FW, (p + 1) / FW, font_addr, na);
                end
            end
            if (p == change_at) begin
                str = p_str; col = p_col; sx = p_sx; sy = p_sy;
            end
            @(negedge clk);
        end
        n_checks++;
        if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL %s blank pix_valid got %b exp 0", tag, pix_valid); end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks += 7;
        if (pix_valid !== 1'b0)   begin n_fail++; $display("FAIL %s pix_valid got %b exp 0", tag, pix_valid); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL %s frame_start got %b exp 0", tag, frame_start); end
        if (pix_ovl !== 1'b0)     begin n_fail++; $display("FAIL %s pix_ovl got %b exp 0", tag, pix_ovl); end
        if (pix_data !== 24'h0)   begin n_fail++; $display("FAIL %s pix_data got %h exp 0", tag, pix_data); end
        if (pix_x !== 8'h0)       begin n_fail++; $display("FAIL %s pix_x got %0d exp 0", tag, pix_x); end
        if (pix_y !== 6'h0)       begin n_fail++; $display("FAIL %s pix_y got %0d exp 0", tag, pix_y); end
        if (font_addr !== 16'h0)  begin n_fail++; $display("FAIL %s font_addr got %0d exp 0", tag, font_addr); end
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b1; read = 1'b0;
        str = 32'h0; col = 96'h0; sx = 8'd0; sy = 6'd0;
        repeat (15) @(negedge clk);
        pulse_read();
        check_idle_outputs("reset");
        rstb = 1'b0;
        repeat (6) @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_first_frame();
        int n;
        str = 32'h303120B0;
        col = {24'hDA3210, 24'h003210, 24'h000000, 24'h0FD210};
        sx = 8'd1; sy = 6'd1;
        pulse_read();
        wait_fs("latency", 20, n);
        n_checks++;
        if (n !== 2) begin n_fail++; $display("FAIL latency got %0d clk exp 2", n); end
        check_frame("first", -1);
        n_checks += 3;
        if (cap_addr[1 * FW + 1] !== 12288) begin n_fail++; $display("FAIL addr_1_1 got %0d exp 12288", cap_addr[FW + 1]); end
        if (cap_addr[1 * FW + 17] !== 12304) begin n_fail++; $display("FAIL addr_17_1 got %0d exp 12304", cap_addr[FW + 17]); end
        if (cap_ovl[0] !== 1'b0) begin n_fail++; $display("FAIL ovl_0_0 got %b exp 0", cap_ovl[0]); end
        for (int y = 1; y <= 16; y++) begin
            for (int x = 1; x <= 16; x++) begin
                if (cap_ovl[y * FW + x]) begin
                    n_checks++;
                    if (cap_data[y * FW + x] !== 24'hDA3210) begin
                        n_fail++; $display("FAIL char0_colour (%0d,%0d) got %h exp DA3210", x, y, cap_data[y * FW + x]);
                    end
                end
            end
            for (int x = 33; x <= 48; x++) begin
                n_checks++;
                if (cap_ovl[y * FW + x] !== 1'b0) begin
                    n_fail++; $display("FAIL space_ovl (%0d,%0d) got %b exp 0", x, y, cap_ovl[y * FW + x]);
                end
            end
        end
    endtask

    task automatic test_mid_frame_change();
        int n;
        wait_fs("period1", 200, n);
        n_checks++;
        if (NPIX + n !== FCYC) begin n_fail++; $display("FAIL period1 got %0d clk exp %0d", NPIX + n, FCYC); end
        p_str = 32'hDEFEF6D6;
        p_col = {$urandom(), $urandom(), $urandom()};
        p_sx = 8'd10; p_sy = 6'd5;
        check_frame("midchange_old", 1000);
        wait_fs("period2", 200, n);
        n_checks++;
        if (NPIX + n !== FCYC) begin n_fail++; $display("FAIL period2 got %0d clk exp %0d", NPIX + n, FCYC); end
        check_frame("midchange_new", -1);
    endtask

    task automatic test_clip();
        int n;
        sx = 8'd70; sy = 6'd25;
        wait_fs("clip", 200, n);
        check_frame("clip", -1);
        sx = 8'd250; sy = 6'd20;
        wait_fs("wrap", 200, n);
        check_frame("wrap", -1);
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 2; i++) begin
            str = $urandom();
            col = {$urandom(), $urandom(), $urandom()};
            sx = 8'($urandom_range(0, 75));
            sy = 6'($urandom_range(0, 28));
            wait_fs("random", 200, n);
            check_frame("random", -1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_fs("pre_reset", 200, n);
        repeat (500) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        pulse_read();
        rstb = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle pix_valid got %b exp 0", pix_valid); end
        end
        str = $urandom();
        col = {$urandom(), $urandom(), $urandom()};
        sx = 8'd3; sy = 6'd2;
        pulse_read();
        wait_fs("restart", 20, n);
        n_checks++;
        if (n !== 2) begin n_fail++; $display("FAIL restart_latency got %0d clk exp 2", n); end
        check_frame("restart", -1);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_mid_frame_change();
        test_clip();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
